// File: rtl/gpu_pixel_fifo_pkg.sv
// Shared geometry and entry-format definitions for the GPU pixel FIFO.
// Entry layout, MSB first: {last, x, y, r, g, b}.
package gpu_pixel_fifo_pkg;

  localparam int GPU_WIDTH_BITS   = 10;
  localparam int GPU_HEIGHT_BITS  = 9;
  localparam int GPU_CHANNEL_BITS = 8;
  localparam int GPU_SCREEN_W     = 640;
  localparam int GPU_SCREEN_H     = 480;
  localparam int GPU_FIFO_DEPTH   = 16;

  function automatic int pixel_entry_bits(input int w, input int h, input int c);
    return 1 + w + h + 3 * c;
  endfunction

  localparam int GPU_PIXEL_ENTRY_BITS =
    pixel_entry_bits(GPU_WIDTH_BITS, GPU_HEIGHT_BITS, GPU_CHANNEL_BITS);

endpackage

// File: rtl/gpu_pixel_fifo_ram.sv
// Pixel storage: register array with a synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module gpu_fifo_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 44,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/gpu_pixel_fifo.sv
// Pixel-stream buffer between the rasteriser (no stall) and the frame writer.
// Head entry is registered; lost pixels are flagged in a sticky overflow bit.
module gpu_pixel_fifo
  import gpu_pixel_fifo_pkg::*;
#(
  parameter int WIDTH_BITS   = GPU_WIDTH_BITS,
  parameter int HEIGHT_BITS  = GPU_HEIGHT_BITS,
  parameter int CHANNEL_BITS = GPU_CHANNEL_BITS,
  parameter int DEPTH        = GPU_FIFO_DEPTH,
  parameter int SCREEN_W     = GPU_SCREEN_W,
  parameter int SCREEN_H     = GPU_SCREEN_H,
  parameter int OVERWRITE    = 0
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [WIDTH_BITS-1:0]     x_i,
  input  logic [HEIGHT_BITS-1:0]    y_i,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  input  logic                      data_avail_i,
  output logic [WIDTH_BITS-1:0]     x_o,
  output logic [HEIGHT_BITS-1:0]    y_o,
  output logic [CHANNEL_BITS-1:0]   r_o,
  output logic [CHANNEL_BITS-1:0]   g_o,
  output logic [CHANNEL_BITS-1:0]   b_o,
  output logic                      last_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      overflow_o,
  input  logic                      clear_ovf_i
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = pixel_entry_bits(WIDTH_BITS, HEIGHT_BITS, CHANNEL_BITS);

  localparam logic [CNT_W-1:0]       LP_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [WIDTH_BITS-1:0]  LP_X_LAST    = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] LP_Y_LAST    = HEIGHT_BITS'(SCREEN_H - 1);
  localparam logic                   LP_OVERWRITE = (OVERWRITE != 0);

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_valid;
  logic               r_full;
  logic               r_ovf;
  logic [ENTRY_W-1:0] r_head;

  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [PTR_W-1:0]   w_wr_ptr_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [ENTRY_W-1:0] w_head_nxt;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_ram_rd;
  logic               w_last_in;
  logic               w_pop;
  logic               w_ovf_evt;
  logic               w_wr_en;
  logic               w_rd_adv;

  assign w_last_in  = (x_i == LP_X_LAST) && (y_i == LP_Y_LAST);
  assign w_wr_entry = {w_last_in, x_i, y_i, r_i, g_i, b_i};

  // A push into a full FIFO with no pop is an overflow; in overwrite mode the
  // oldest entry is retired so the new one can take its slot.
  assign w_pop     = r_valid & ready_i;
  assign w_ovf_evt = data_avail_i & r_full & ~w_pop;
  assign w_wr_en   = data_avail_i & (~r_full | w_pop | LP_OVERWRITE);
  assign w_rd_adv  = w_pop | (w_ovf_evt & LP_OVERWRITE);

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (w_rd_adv) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
    end
    if (w_wr_en) begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
    end
    case ({w_wr_en, w_rd_adv})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // The new head slot may be the one being written on this same edge.
  always_comb begin
    w_head_nxt = w_ram_rd;
    if (w_wr_en && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_nxt = w_wr_entry;
    end
  end

  gpu_fifo_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .ADDR_W  (PTR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (w_rd_ptr_nxt),
    .o_rd_data (w_ram_rd)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_full   <= (w_count_nxt == LP_DEPTH_CNT);
      r_head   <= w_head_nxt;
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign {last_o, x_o, y_o, r_o, g_o, b_o} = r_head;
  assign valid_o    = r_valid;
  assign count_o    = r_count;
  assign full_o     = r_full;
  assign overflow_o = r_ovf;

endmodule
